// File: rtl/mips_mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// The master side is the controller: it consumes decode/status inputs and
// drives every datapath select and strobe.
interface mips_mc_control_fsm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_BITS = 4
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;
    logic                  align_err;

    logic                  PCWrite;
    logic                  IorD;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            RegDst;
    logic [1:0]            MemtoReg;
    logic                  RegWrite;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUControl;
    logic [1:0]            PCSrc;
    logic                  halted;
    logic [DATA_WIDTH-1:0] retired;
    logic [STATE_BITS-1:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready, align_err,
        output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, halted, retired, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready, align_err,
        input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, halted, retired, state_dbg
    );
endinterface

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, stalls on mem_ready, halts on bad opcodes or
// PC misalignment, and counts retired instructions. Outputs are forced to 0
// combinationally while reset is low so nothing strobes after the reset edge.
module mips_mc_control_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_mc_control_fsm_if.master  ctl_if
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPE  = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_ERROR  = 4'd15
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_SLL = 3'b011,
                           ALU_SRL = 3'b100, ALU_LUI = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ANDI  = 6'h0C, OP_ORI = 6'h0D, OP_LUI  = 6'h0F,
                           OP_LW    = 6'h23, OP_SW  = 6'h2B;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_retired;

    logic       w_pc_write, w_iord, w_mem_write, w_ir_write, w_reg_write;
    logic       w_alu_src_a, w_halted, w_retire;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_ctl;

    // State register; reset parks the machine in FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, bumped on the edge leaving a retiring state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + DATA_WIDTH'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 2'd0;
        w_mem_to_reg = 2'd0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'd0;
        w_alu_ctl    = ALU_AND;
        w_pc_src     = 2'd0;
        w_halted     = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (ctl_if.align_err) begin
                    w_next_state = S_ERROR;
                end else begin
                    w_alu_src_b  = 2'd1;
                    w_alu_ctl    = ALU_ADD;
                    w_ir_write   = ctl_if.mem_ready;
                    w_pc_write   = ctl_if.mem_ready;
                    w_next_state = ctl_if.mem_ready ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target into ALUOut while the opcode is decoded.
                w_alu_src_b = 2'd3;
                w_alu_ctl   = ALU_ADD;
                case (ctl_if.opcode)
                    OP_LW, OP_SW:                     w_next_state = S_MEMADR;
                    OP_RTYPE:                         w_next_state = (ctl_if.funct == 6'h08) ? S_JR : S_RTYPE;
                    OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_IMMEX;
                    OP_J:                             w_next_state = S_JUMP;
                    OP_JAL:                           w_next_state = S_JAL;
                    default:                          w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'd2;
                w_alu_ctl    = ALU_ADD;
                w_next_state = (ctl_if.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord       = 1'b1;
                w_next_state = ctl_if.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_mem_to_reg = 2'd1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (ctl_if.mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_RTYPE: begin
                w_alu_src_a  = 1'b1;
                w_next_state = S_ALUWB;
                case (ctl_if.funct)
                    6'h20:   w_alu_ctl = ALU_ADD;
                    6'h22:   w_alu_ctl = ALU_SUB;
                    6'h24:   w_alu_ctl = ALU_AND;
                    6'h25:   w_alu_ctl = ALU_OR;
                    6'h2A:   w_alu_ctl = ALU_SLT;
                    6'h00:   w_alu_ctl = ALU_SLL;
                    6'h02:   w_alu_ctl = ALU_SRL;
                    default: w_next_state = S_ERROR;
                endcase
            end
            S_ALUWB: begin
                w_reg_dst    = 2'd1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_ctl    = ALU_SUB;
                w_pc_src     = 2'd1;
                w_pc_write   = (ctl_if.opcode == OP_BNE) ? ~ctl_if.zero : ctl_if.zero;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_IMMEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'd2;
                w_next_state = S_IMMWB;
                case (ctl_if.opcode)
                    OP_ANDI: w_alu_ctl = ALU_AND;
                    OP_ORI:  w_alu_ctl = ALU_OR;
                    OP_LUI:  w_alu_ctl = ALU_LUI;
                    default: w_alu_ctl = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = 2'd2;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, so link and jump share one cycle.
                w_reg_dst    = 2'd2;
                w_mem_to_reg = 2'd2;
                w_reg_write  = 1'b1;
                w_pc_src     = 2'd2;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JR: begin
                w_pc_src     = 2'd3;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ERROR: begin
                w_halted     = 1'b1;
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_ERROR;
            end
        endcase
    end

    // Output drive, held at 0 asynchronously while reset is low.
    always_comb begin
        if (reset) begin
            ctl_if.PCWrite    = w_pc_write;
            ctl_if.IorD       = w_iord;
            ctl_if.MemWrite   = w_mem_write;
            ctl_if.IRWrite    = w_ir_write;
            ctl_if.RegDst     = w_reg_dst;
            ctl_if.MemtoReg   = w_mem_to_reg;
            ctl_if.RegWrite   = w_reg_write;
            ctl_if.ALUSrcA    = w_alu_src_a;
            ctl_if.ALUSrcB    = w_alu_src_b;
            ctl_if.ALUControl = w_alu_ctl;
            ctl_if.PCSrc      = w_pc_src;
            ctl_if.halted     = w_halted;
            ctl_if.retired    = r_retired;
            ctl_if.state_dbg  = STATE_BITS'(r_state);
        end else begin
            ctl_if.PCWrite    = 1'b0;
            ctl_if.IorD       = 1'b0;
            ctl_if.MemWrite   = 1'b0;
            ctl_if.IRWrite    = 1'b0;
            ctl_if.RegDst     = 2'd0;
            ctl_if.MemtoReg   = 2'd0;
            ctl_if.RegWrite   = 1'b0;
            ctl_if.ALUSrcA    = 1'b0;
            ctl_if.ALUSrcB    = 2'd0;
            ctl_if.ALUControl = 3'd0;
            ctl_if.PCSrc      = 2'd0;
            ctl_if.halted     = 1'b0;
            ctl_if.retired    = '0;
            ctl_if.state_dbg  = '0;
        end
    end
endmodule
